// File: rtl/bus_xfer_sequencer.sv
// bus_xfer_sequencer
//   Initiator side of the datapath bus. It accepts register-transfer requests
//   (source index, destination index) over a valid/ready handshake and queues
//   them in a small FIFO. Each request drives one one-hot source out-enable
//   for SETTLE cycles. The matching one-hot destination in-enable then pulses
//   for one cycle to latch the bus.
//
// Parameters
//   QDEPTH  request FIFO depth (power of 2, >= 2)
//   SETTLE  DRIVE cycles before LATCH (1..7)
//
// Ports
//   clock       system clock, rising edge
//   clear       synchronous active-high reset
//   req_valid   request present
//   req_ready   FIFO can accept a request
//   req_src     source index (0..23 legal)
//   req_dst     destination index (0..23 legal)
//   src_out     one-hot source out-enables
//   dst_in      one-hot destination in-enables
//   done        one-cycle pulse after a transfer latches
//   err         one-cycle pulse after an out-of-range request is dropped
//   busy        sequencer active or FIFO not empty
//   xfer_count  saturating count of done pulses  (BUS_XFER_STATS_EN only)
//   err_count   saturating count of err pulses   (BUS_XFER_STATS_EN only)
//
// Build option
//   BUS_XFER_STATS_EN  adds the xfer_count / err_count statistics outputs.
//
// FSM states
//   state | meaning
//   IDLE  | no transfer; pop the FIFO head when one is present
//   DRIVE | src_out asserted; settle counter runs down to zero
//   LATCH | src_out held, dst_in asserted for one cycle; chain to next request

module bus_xfer_sequencer #(
   parameter int QDEPTH = 2,
   parameter int SETTLE = 1
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_src,
   input  logic [4:0]  req_dst,
   output logic [23:0] src_out,
   output logic [23:0] dst_in,
   output logic        done,
   output logic        err,
`ifdef BUS_XFER_STATS_EN
   output logic [15:0] xfer_count,
   output logic [7:0]  err_count,
`endif
   output logic        busy
);

   localparam int AW = $clog2(QDEPTH);
   localparam int CW = AW + 1;
   localparam logic [2:0]    SETTLE_LD = 3'(SETTLE - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(QDEPTH);
   localparam logic [4:0]    MAX_IDX   = 5'd23;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      LATCH = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [4:0]    src_q, src_d;
   logic [4:0]    dst_q, dst_d;
   logic [2:0]    settle_q, settle_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          init_q, init_d;
   logic [9:0]    mem_q [QDEPTH];

   logic          full, empty;
   logic          accept, bad_req, push, pop;
   logic [9:0]    head;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];

   // init_q holds ready low through clear and for the edge that releases it
   assign req_ready = init_q && !full;
   assign accept    = req_valid && req_ready;
   assign bad_req   = (req_src > MAX_IDX) || (req_dst > MAX_IDX);
   assign push      = accept && !bad_req;

   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      settle_d = settle_q;
      pop      = 1'b0;

      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop      = 1'b1;
               src_d    = head[9:5];
               dst_d    = head[4:0];
               settle_d = SETTLE_LD;
               state_d  = DRIVE;
            end
         end
         DRIVE: begin
            if (settle_q == 3'd0) begin
               state_d = LATCH;
            end else begin
               settle_d = settle_q - 3'd1;
            end
         end
         LATCH: begin
            if (!empty) begin
               pop      = 1'b1;
               src_d    = head[9:5];
               dst_d    = head[4:0];
               settle_d = SETTLE_LD;
               state_d  = DRIVE;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      done_d   = (state_q == LATCH);
      err_d    = accept && bad_req;
      init_d   = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q  <= IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         settle_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         init_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         settle_q <= settle_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         done_q   <= done_d;
         err_q    <= err_d;
         init_q   <= init_d;
      end
   end

   // storage carries no reset; occupancy is tracked by count_q alone
   always_ff @(posedge clock) begin
      if (push && !clear) begin
         mem_q[wr_ptr_q] <= {req_src, req_dst};
      end
   end

   assign src_out = ((state_q == DRIVE) || (state_q == LATCH)) ? (24'd1 << src_q) : 24'd0;
   assign dst_in  = (state_q == LATCH) ? (24'd1 << dst_q) : 24'd0;
   assign done    = done_q;
   assign err     = err_q;
   assign busy    = (state_q != IDLE) || !empty;

`ifdef BUS_XFER_STATS_EN
   logic [15:0] xfer_cnt_q, xfer_cnt_d;
   logic [7:0]  err_cnt_q, err_cnt_d;

   always_comb begin
      xfer_cnt_d = xfer_cnt_q;
      err_cnt_d  = err_cnt_q;
      if (done_q && (xfer_cnt_q != 16'hFFFF)) xfer_cnt_d = xfer_cnt_q + 16'd1;
      if (err_q && (err_cnt_q != 8'hFF))      err_cnt_d  = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         xfer_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         xfer_cnt_q <= xfer_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign xfer_count = xfer_cnt_q;
   assign err_count  = err_cnt_q;
`endif

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
module tb_bus_xfer_sequencer;

   logic        clock = 1'b0;
   logic        clear;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_src;
   logic [4:0]  req_dst;
   logic [23:0] src_out;
   logic [23:0] dst_in;
   logic        done;
   logic        err;
   logic        busy;
`ifdef BUS_XFER_STATS_EN
   logic [15:0] xfer_count;
   logic [7:0]  err_count;
`endif

   always #5 clock = ~clock;

   bus_xfer_sequencer #(.QDEPTH(2), .SETTLE(1)) dut (
      .clock      (clock),
      .clear      (clear),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_src    (req_src),
      .req_dst    (req_dst),
      .src_out    (src_out),
      .dst_in     (dst_in),
      .done       (done),
      .err        (err),
`ifdef BUS_XFER_STATS_EN
      .xfer_count (xfer_count),
      .err_count  (err_count),
`endif
      .busy       (busy)
   );

   int n_err = 0;
   int n_chk = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // bus monitor: latch events, pulse counts and invariant violations
   logic [47:0] log_q [$];
   int done_cnt = 0;
   int err_cnt  = 0;
   int inv_viol = 0;

   always @(negedge clock) begin
      if (dst_in != 24'd0) log_q.push_back({src_out, dst_in});
      if (done) done_cnt++;
      if (err) err_cnt++;
      if ((dst_in != 24'd0 && src_out == 24'd0) || !$onehot0(src_out) || !$onehot0(dst_in))
         inv_viol++;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [4:0] s, input logic [4:0] d);
      int w;
      req_src   = s;
      req_dst   = d;
      req_valid = 1'b1;
      w = 0;
      while (!req_ready && w < 40) begin
         step();
         w++;
      end
      check("send_ready_timeout", 32'(w < 40), 32'd1);
      step();
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int base, input int target);
      int w;
      w = 0;
      while ((done_cnt - base) < target && w < 80) begin
         step();
         w++;
      end
      repeat (3) step();
      check(tag, 32'(done_cnt - base), 32'(target));
   endtask

   logic [4:0] t3_src [5] = '{5'd1, 5'd2, 5'd4, 5'd6, 5'd9};
   logic [4:0] t3_dst [5] = '{5'd2, 5'd3, 5'd5, 5'd8, 5'd10};

   initial begin
      int base_done, base_err, base_log, idx, saw_stall, acc_now;
      logic [47:0] entry;

      clear = 1'b1;
      req_valid = 1'b0;
      req_src = '0;
      req_dst = '0;

      // reset then single PC -> MAR transfer
      step();
      step();
      check("rst_src_out", 32'(src_out), 32'h0);
      check("rst_dst_in",  32'(dst_in),  32'h0);
      check("rst_done",    32'(done),    32'd0);
      check("rst_err",     32'(err),     32'd0);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_ready_during_clear", 32'(req_ready), 32'd0);
      clear = 1'b0;
      step();
      check("rst_ready_after", 32'(req_ready), 32'd1);

      send(5'd21, 5'd16);
      check("t1_busy_queued", 32'(busy), 32'd1);
      check("t1_src_idle",    32'(src_out), 32'h0);
      step();
      check("t1_drive_src", 32'(src_out), 32'h200000);
      check("t1_drive_dst", 32'(dst_in),  32'h0);
      step();
      check("t1_latch_src", 32'(src_out), 32'h200000);
      check("t1_latch_dst", 32'(dst_in),  32'h010000);
      check("t1_latch_done", 32'(done),   32'd0);
      step();
      check("t1_done",      32'(done),    32'd1);
      check("t1_src_off",   32'(src_out), 32'h0);
      check("t1_busy_off",  32'(busy),    32'd0);
      step();
      check("t1_done_one_cycle", 32'(done), 32'd0);

      // back-to-back R3 -> Y then MDR -> R7
      send(5'd3, 5'd22);
      send(5'd16, 5'd7);
      check("t2_c1_src", 32'(src_out), 32'h000008);
      check("t2_c1_dst", 32'(dst_in),  32'h0);
      step();
      check("t2_c2_src", 32'(src_out), 32'h000008);
      check("t2_c2_dst", 32'(dst_in),  32'h400000);
      check("t2_c2_done", 32'(done),   32'd0);
      step();
      check("t2_c3_src", 32'(src_out), 32'h010000);
      check("t2_c3_dst", 32'(dst_in),  32'h0);
      check("t2_c3_done", 32'(done),   32'd1);
      step();
      check("t2_c4_src", 32'(src_out), 32'h010000);
      check("t2_c4_dst", 32'(dst_in),  32'h000080);
      check("t2_c4_done", 32'(done),   32'd0);
      step();
      check("t2_c5_done", 32'(done),   32'd1);
      check("t2_c5_src",  32'(src_out), 32'h0);
      step();

      // FIFO full with valid held for five requests
      base_done = done_cnt;
      base_log  = log_q.size();
      idx = 0;
      saw_stall = 0;
      req_src = t3_src[0];
      req_dst = t3_dst[0];
      req_valid = 1'b1;
      for (int c = 0; c < 60 && idx < 5; c++) begin
         acc_now = int'(req_ready);
         if (!req_ready) saw_stall = 1;
         step();
         if (acc_now != 0) begin
            idx++;
            if (idx < 5) begin
               req_src = t3_src[idx];
               req_dst = t3_dst[idx];
            end
         end
      end
      req_valid = 1'b0;
      check("t3_all_accepted", 32'(idx), 32'd5);
      check("t3_ready_dropped", 32'(saw_stall), 32'd1);
      wait_done("t3_done_count", base_done, 5);
      check("t3_latch_count", 32'(log_q.size() - base_log), 32'd5);
      for (int i = 0; i < 5; i++) begin
         entry = (base_log + i < log_q.size()) ? log_q[base_log + i] : 48'h0;
         check("t3_order_src", 32'(entry[47:24]), 32'd1 << t3_src[i]);
         check("t3_order_dst", 32'(entry[23:0]),  32'd1 << t3_dst[i]);
      end

      // invalid request, then a legal R5 -> R5
      base_done = done_cnt;
      base_err  = err_cnt;
      base_log  = log_q.size();
      send(5'd24, 5'd3);
      check("t4_err_pulse", 32'(err),     32'd1);
      check("t4_src_quiet", 32'(src_out), 32'h0);
      check("t4_busy",      32'(busy),    32'd0);
      step();
      check("t4_err_one_cycle", 32'(err), 32'd0);
      repeat (4) step();
      check("t4_err_count",  32'(err_cnt - base_err),     32'd1);
      check("t4_no_done",    32'(done_cnt - base_done),   32'd0);
      check("t4_no_latch",   32'(log_q.size() - base_log), 32'd0);
      send(5'd5, 5'd5);
      wait_done("t4_follow_done", base_done, 1);
      entry = (log_q.size() > base_log) ? log_q[base_log] : 48'h0;
      check("t4_follow_xfer", 32'(entry[47:24]), 32'h20);
      check("t4_follow_dst",  32'(entry[23:0]),  32'h20);

      // clear during DRIVE of R1 -> R2 with another request queued
      send(5'd1, 5'd2);
      send(5'd7, 5'd9);
      check("t5_drive_src", 32'(src_out), 32'h000002);
      base_done = done_cnt;
      base_log  = log_q.size();
      clear = 1'b1;
      step();
      check("t5_src_cleared",  32'(src_out), 32'h0);
      check("t5_dst_cleared",  32'(dst_in),  32'h0);
      check("t5_busy_cleared", 32'(busy),    32'd0);
      check("t5_done_cleared", 32'(done),    32'd0);
      clear = 1'b0;
      repeat (8) step();
      check("t5_no_latch", 32'(log_q.size() - base_log), 32'd0);
      check("t5_no_done",  32'(done_cnt - base_done),     32'd0);
      check("t5_idle",     32'(busy),                     32'd0);

`ifdef BUS_XFER_STATS_EN
      check("t6_xfer_zero", 32'(xfer_count), 32'd0);
      check("t6_err_zero",  32'(err_count),  32'd0);
      base_done = done_cnt;
      send(5'd0, 5'd1);
      send(5'd25, 5'd1);
      send(5'd2, 5'd3);
      send(5'd4, 5'd6);
      wait_done("t6_done", base_done, 3);
      check("t6_xfer_count", 32'(xfer_count), 32'd3);
      check("t6_err_count",  32'(err_count),  32'd1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      step();
      check("t6_xfer_cleared", 32'(xfer_count), 32'd0);
      check("t6_err_cleared",  32'(err_count),  32'd0);
`endif

      check("invariants", 32'(inv_viol), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/bus_xfer_sequencer.md
Name: bus_xfer_sequencer

Overview:
Initiator side of the datapath bus. It accepts register-transfer requests (source index, destination index) through a valid/ready handshake and queues them in a small FIFO. For each request it drives exactly one one-hot source out-enable (R0out..Cout) onto the bus selector, then pulses the matching one-hot destination in-enable to latch the bus value. It sits between the control unit and the bus/register file.

Parameters:
QDEPTH, 2, request FIFO depth; power of 2, minimum 2.
SETTLE, 1, number of DRIVE cycles before LATCH; range 1..7.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
clear  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  request FIFO can accept a request.
req_src  input  5  source index: 0-15 = R0-R15, 16 = MDR, 17 = HI, 18 = LO, 19 = Zhigh, 20 = Zlow, 21 = PC, 22 = InPort, 23 = C.
req_dst  input  5  destination index: 0-15 = R0-R15, 16 = MAR, 17 = MDR, 18 = HI, 19 = LO, 20 = PC, 21 = IR, 22 = Y, 23 = OutPort.
src_out  output  24  one-hot source out-enables; bit n corresponds to source index n.
dst_in  output  24  one-hot destination in-enables; bit n corresponds to destination index n.
done  output  1  one-cycle pulse when a transfer completes.
err  output  1  one-cycle pulse when an out-of-range request is dropped.
busy  output  1  high when state is not IDLE or the FIFO is not empty.

Behaviour:
- Reset (clear high at a clock edge):
  - State goes to IDLE.
  - FIFO is flushed.
  - src_out, dst_in, done and err all go to 0.
  - req_ready goes to 1 on the cycle after clear deasserts.
- A transfer in progress when clear is applied is aborted. Its dst_in is never asserted.
- Handshake:
  - A request is accepted at an edge where req_valid && req_ready.
  - req_ready = !full. There is no push when full, even if a pop happens in the same cycle.
- Invalid requests (req_src > 23 or req_dst > 23):
  - Still accepted.
  - Not enqueued.
  - err pulses high in the cycle after acceptance.
  - No bus activity results.
- Push and pop in the same cycle are allowed when the FIFO is neither full nor empty. Pointers wrap modulo QDEPTH.
- There is no empty-FIFO bypass: a request must be stored before it can be popped.
- States:
  - IDLE: all outputs 0. If the FIFO is not empty, pop it, load src/dst and the settle counter, and go to DRIVE.
  - DRIVE: src_out = 1<<src, dst_in = 0. Stay for SETTLE cycles, then go to LATCH.
  - LATCH: src_out held, dst_in = 1<<dst for exactly one cycle. Then:
    - if the FIFO is not empty, pop and go to DRIVE (back-to-back);
    - otherwise go to IDLE.
- done is registered: high the cycle after LATCH, for one cycle.
- Latency: a request accepted at edge N appears on src_out from cycle N+2. LATCH occurs SETTLE cycles after src_out first appears. done follows one cycle after LATCH.
- Sustained throughput is 1 transfer per SETTLE+1 cycles.
- Invariants:
  - src_out is never changed between DRIVE and LATCH of the same transfer.
  - At most one bit is set in each of src_out and dst_in.
  - dst_in is never high in a cycle where src_out is 0.
- src index equal to dst index (for example R5 to R5) is legal and runs normally.

Optional Feature:
BUS_XFER_STATS_EN defined:
- Adds output xfer_count (16 bits), incremented on each done pulse.
- Adds output err_count (8 bits), incremented on each err pulse.
- Both counters saturate at all-ones and are zeroed by clear.

BUS_XFER_STATS_EN undefined:
- Neither port nor any counter logic exists.
- All other behaviour is identical.

Test Plan:
- Reset then single request: clear for 2 cycles, then src=21 (PC), dst=16 (MAR), SETTLE=1. Required: src_out=0x200000 for 2 cycles; dst_in=0x010000 in the second of those cycles; done high 1 cycle later; busy falls after done.
- Back-to-back, SETTLE=1: enqueue R3->Y, then MDR->R7. Required: src_out sequence 0x000008,0x000008,0x010000,0x010000 with no idle gap; dst_in=0x400000 then 0x000080; two done pulses 2 cycles apart.
- FIFO full, QDEPTH=2, req_valid held for 5 requests: req_ready drops after the FIFO fills and no request is lost or duplicated. Required: all 5 transfers complete in order with 5 done pulses.
- Invalid request src=24, dst=3: accepted. Required: err pulses once; src_out and dst_in stay 0; done is not pulsed; a following valid request executes normally.
- Reset mid-operation: assert clear during DRIVE of R1->R2. Required: dst_in bit 2 never asserts; all outputs 0 the next cycle; queued requests are discarded.
- With BUS_XFER_STATS_EN: 3 valid requests and 1 invalid request. Required: xfer_count=3, err_count=1; clear returns both to 0.
